axi_inval_queue: RTL and testbench
==================================

AXI_INVAL_QUEUE -- requirements
Module: axi_inval_queue

Interface
REQ-001 SHALL have parameter Depth, default 4, meaning the number of queue entries; it is a power of two and at least 2.
REQ-002 SHALL have parameter AddrWidth, default 64, meaning the invalidation address width in bits.
REQ-003 SHALL have parameter L1LineWidth, default 16, meaning the L1 D-cache line size in bytes; it is a power of two.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port en_i, input, 1 bit: coherence enable from the accelerator request.
REQ-007 SHALL have port inval_addr_i, input, AddrWidth bits: invalidation address from the AXI invalidation filter.
REQ-008 SHALL have port inval_valid_i, input, 1 bit: upstream valid.
REQ-009 SHALL have port inval_ready_o, output, 1 bit: upstream ready.
REQ-010 SHALL have port inval_addr_o, output, AddrWidth bits: line-aligned address to the core.
REQ-011 SHALL have port inval_valid_o, output, 1 bit: downstream valid.
REQ-012 SHALL have port inval_ready_i, input, 1 bit: downstream ready from the core.
REQ-013 SHALL have port count_o, output, $clog2(Depth)+1 bits: current occupancy.
REQ-014 SHALL have port coalesced_o, output, 16 bits: saturating count of merged requests.

Function
REQ-015 SHALL line-align every incoming address by clearing bits [$clog2(L1LineWidth)-1:0] before comparing or storing it.
REQ-016 SHALL implement a circular FIFO with read pointer, write pointer (each modulo Depth, wrapping from Depth-1 to 0) and an occupancy counter.
REQ-017 SHALL define "push" as inval_valid_i & inval_ready_o, and "pop" as inval_valid_o & inval_ready_i.
REQ-018 SHALL drive inval_valid_o = (count_o != 0) and inval_addr_o = entry[rd_ptr], with no fall-through: an entry pushed in cycle N is first visible in cycle N+1.
REQ-019 SHALL define a coalesce hit as: en_i=1, count_o>0, the aligned input equals entry[wr_ptr-1], and that entry is not being popped this cycle (not the case count_o==1 with pop=1).
REQ-020 SHALL, on a push with a coalesce hit, accept the request without storing it and increment coalesced_o, saturating at 16'hFFFF.
REQ-021 SHALL drive inval_ready_o = 1 when en_i=0, when a coalesce hit occurs, or when count_o<Depth; otherwise 0. There is no same-cycle pop bypass when full.
REQ-022 SHALL, on a push with en_i=0, discard the request: no store and no counter change.
REQ-023 SHALL, on a push with en_i=1 and no hit, store the request at wr_ptr and advance wr_ptr.
REQ-024 SHALL keep draining queued entries while en_i=0.
REQ-025 SHALL, on a simultaneous store and pop, leave count_o unchanged and advance both pointers.
REQ-026 SHALL hold inval_addr_o stable while inval_valid_o=1 and inval_ready_i=0.
REQ-027 SHALL never overflow, since no store occurs when full, and never underflow, since a pop requires valid.

Reset
REQ-028 SHALL, when rst_ni=0 at a clock edge, clear rd_ptr, wr_ptr, count_o and coalesced_o to 0, which gives inval_valid_o=0.
REQ-029 SHALL, during reset, drive inval_ready_o per REQ-021 using count=0, i.e. 1; pushes in reset cycles are discarded.
REQ-030 SHALL lose any in-flight entries on a mid-operation reset; storage contents need no reset.

Verification
REQ-031 SHALL cover this scenario: en_i=1, push 0x1005, then 0x2000 with inval_ready_i=0 -> count_o=2; with ready=1, outputs 0x1000 then 0x2000 in successive cycles.
REQ-032 SHALL cover this scenario: en_i=1, push 0x3000 then 0x300C back-to-back, no pop -> count_o=1, coalesced_o=1, single output 0x3000.
REQ-033 SHALL cover this scenario: Depth=4, ready=0, push 4 distinct lines -> inval_ready_o=0; a fifth distinct push stalls; a fifth push matching the last line is accepted with coalesced_o+1.
REQ-034 SHALL cover this scenario: count_o=1 holding 0x4000 with pop this cycle, and push 0x4000 -> stored (no coalesce); count_o stays 1 and 0x4000 is output again.
REQ-035 SHALL cover this scenario: en_i=0 with 2 entries queued, push 0x5000 -> accepted and dropped; both entries drain; count_o=0.
REQ-036 SHALL cover this scenario: 3 entries queued, rst_ni=0 for one cycle -> count_o=0, inval_valid_o=0, coalesced_o=0; more than Depth wrap-around pushes afterwards keep address order.

Source files
------------

// File: rtl/axi_inval_queue.sv
// axi_inval_queue: line-aligned invalidation FIFO that merges back-to-back
// requests to the line most recently written into the queue.
module axi_inval_queue #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [AddrWidth-1:0]       inval_addr_i,
    input  logic                       inval_valid_i,
    output logic                       inval_ready_o,
    output logic [AddrWidth-1:0]       inval_addr_o,
    output logic                       inval_valid_o,
    input  logic                       inval_ready_i,
    output logic [$clog2(Depth):0]     count_o,
    output logic [15:0]                coalesced_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, last_ptr;
    logic [CntW-1:0]      count_q, count_d;
    logic [15:0]          coalesced_q, coalesced_d;
    logic [AddrWidth-1:0] aligned;
    logic                 hit, push, pop, store;

    always_comb begin
        aligned       = inval_addr_i & ~AddrWidth'(L1LineWidth - 1);
        last_ptr      = wr_ptr_q - 1'b1;
        inval_valid_o = count_q != '0;
        inval_addr_o  = mem_q[rd_ptr_q];
        pop           = inval_valid_o & inval_ready_i;
        // the newest entry cannot absorb a request in the cycle it leaves the queue
        hit           = en_i && inval_valid_o && aligned == mem_q[last_ptr]
                        && !(count_q == CntW'(1) && pop);
        inval_ready_o = !rst_ni || !en_i || hit || count_q < CntW'(Depth);
        push          = inval_valid_i & inval_ready_o;
        store         = push & en_i & ~hit;
        wr_ptr_d      = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q + CntW'(store) - CntW'(pop);
        coalesced_d   = (push && hit && coalesced_q != 16'hFFFF) ? coalesced_q + 16'd1
                                                                : coalesced_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            coalesced_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            coalesced_q <= coalesced_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_ptr_q] <= aligned;
    end

    assign count_o     = count_q;
    assign coalesced_o = coalesced_q;
endmodule

// File: tb/tb_axi_inval_queue.sv
// tb_axi_inval_queue: directed checks of ordering, merging, back-pressure,
// enable-off dropping and reset for the invalidation queue.
module tb_axi_inval_queue;
    logic        clk_i = 1'b0;
    logic        rst_ni, en_i, inval_valid_i, inval_ready_i;
    logic [63:0] inval_addr_i, inval_addr_o;
    logic        inval_ready_o, inval_valid_o;
    logic [2:0]  count_o;
    logic [15:0] coalesced_o;
    int          checks = 0;
    int          errors = 0;

    axi_inval_queue #(.Depth(4), .AddrWidth(64), .L1LineWidth(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .inval_addr_i(inval_addr_i), .inval_valid_i(inval_valid_i),
        .inval_ready_o(inval_ready_o), .inval_addr_o(inval_addr_o),
        .inval_valid_o(inval_valid_o), .inval_ready_i(inval_ready_i),
        .count_o(count_o), .coalesced_o(coalesced_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic en, input logic v, input logic [63:0] a, input logic r);
        en_i          = en;
        inval_valid_i = v;
        inval_addr_i  = a;
        inval_ready_i = r;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1, 0, 64'h0, 0);
        tick();
        drive(1, 1, 64'h9000, 0);
        chk("ready_in_reset", 64'(inval_ready_o), 64'd1);
        tick();
        rst_ni = 1'b1;
        drive(1, 0, 64'h0, 0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(inval_valid_o), 64'd0);
        chk("rst_coal", 64'(coalesced_o), 64'd0);

        // ordered delivery with back-pressure
        drive(1, 1, 64'h1005, 0);
        chk("ready_empty", 64'(inval_ready_o), 64'd1);
        tick();
        drive(1, 1, 64'h2000, 0);
        tick();
        drive(1, 0, 64'h0, 0);
        chk("s1_count", 64'(count_o), 64'd2);
        chk("s1_valid", 64'(inval_valid_o), 64'd1);
        chk("s1_hold", inval_addr_o, 64'h1000);
        tick();
        chk("s1_stable", inval_addr_o, 64'h1000);
        drive(1, 0, 64'h0, 1);
        chk("s1_out0", inval_addr_o, 64'h1000);
        tick();
        chk("s1_out1", inval_addr_o, 64'h2000);
        chk("s1_cnt1", 64'(count_o), 64'd1);
        tick();
        chk("s1_empty", 64'(count_o), 64'd0);
        chk("s1_novalid", 64'(inval_valid_o), 64'd0);

        // same-line merge
        drive(1, 1, 64'h3000, 0);
        tick();
        drive(1, 1, 64'h300C, 0);
        chk("s2_ready", 64'(inval_ready_o), 64'd1);
        tick();
        drive(1, 0, 64'h0, 0);
        chk("s2_count", 64'(count_o), 64'd1);
        chk("s2_coal", 64'(coalesced_o), 64'd1);
        chk("s2_addr", inval_addr_o, 64'h3000);
        drive(1, 0, 64'h0, 1);
        tick();
        chk("s2_empty", 64'(count_o), 64'd0);

        // full queue: stall distinct, merge matching (pointer wraps here)
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 64'h6000 + 64'(i) * 64'h40, 0);
            tick();
        end
        drive(1, 1, 64'h6100, 0);
        chk("s3_full", 64'(count_o), 64'd4);
        chk("s3_stall", 64'(inval_ready_o), 64'd0);
        tick();
        chk("s3_nostore", 64'(count_o), 64'd4);
        drive(1, 1, 64'h60C5, 0);
        chk("s3_hit_ready", 64'(inval_ready_o), 64'd1);
        tick();
        drive(1, 0, 64'h0, 1);
        chk("s3_coal", 64'(coalesced_o), 64'd2);
        chk("s3_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("s3_drain", inval_addr_o, 64'h6000 + 64'(i) * 64'h40);
            tick();
        end
        chk("s3_empty", 64'(count_o), 64'd0);

        // popping entry cannot absorb a matching push
        drive(1, 1, 64'h4000, 0);
        tick();
        drive(1, 1, 64'h4000, 1);
        chk("s4_ready", 64'(inval_ready_o), 64'd1);
        tick();
        drive(1, 0, 64'h0, 0);
        chk("s4_count", 64'(count_o), 64'd1);
        chk("s4_addr", inval_addr_o, 64'h4000);
        chk("s4_coal", 64'(coalesced_o), 64'd2);
        drive(1, 0, 64'h0, 1);
        tick();
        chk("s4_empty", 64'(count_o), 64'd0);

        // enable off: drop incoming, keep draining
        drive(1, 1, 64'h7000, 0);
        tick();
        drive(1, 1, 64'h7040, 0);
        tick();
        drive(0, 1, 64'h5000, 0);
        chk("s5_ready", 64'(inval_ready_o), 64'd1);
        tick();
        drive(0, 1, 64'h7040, 0);
        tick();
        drive(0, 0, 64'h0, 0);
        chk("s5_count", 64'(count_o), 64'd2);
        chk("s5_coal", 64'(coalesced_o), 64'd2);
        drive(0, 0, 64'h0, 1);
        chk("s5_out0", inval_addr_o, 64'h7000);
        tick();
        chk("s5_out1", inval_addr_o, 64'h7040);
        tick();
        chk("s5_empty", 64'(count_o), 64'd0);

        // mid-operation reset, then wrap-around streaming
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 64'h8000 + 64'(i) * 64'h40, 0);
            tick();
        end
        drive(1, 0, 64'h0, 0);
        chk("s6_pre", 64'(count_o), 64'd3);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        chk("s6_count", 64'(count_o), 64'd0);
        chk("s6_valid", 64'(inval_valid_o), 64'd0);
        chk("s6_coal", 64'(coalesced_o), 64'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 64'hA000 + 64'(i) * 64'h40, 1);
            if (i > 0) begin
                chk("s6_order", inval_addr_o, 64'hA000 + 64'(i - 1) * 64'h40);
                chk("s6_cnt", 64'(count_o), 64'd1);
            end
            tick();
        end
        drive(1, 0, 64'h0, 1);
        chk("s6_last", inval_addr_o, 64'hA180);
        tick();
        chk("s6_empty", 64'(count_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
